// File: rtl/temp_sensor_avg_ctrl.sv
// temp_sensor_avg_ctrl
//   Sequencer/averager wrapped around the temperature-sensor pulse-length
//   measurement block. It triggers a measurement, waits for the result,
//   idles for a programmable gap, and repeats until 2^AVG_LOG2 samples have
//   been collected. It then publishes the truncated mean with a one-cycle
//   strobe. A missing sensor response aborts the run and raises a sticky
//   error flag.
//
// Ports
//   clk_100MHz    system clock, rising edge
//   RESET_N       asynchronous active-low reset
//   start         request one averaging run (honoured only in IDLE)
//   continuous    restart automatically after each completed run
//   interval      gap cycles between result and next trigger (0 acts as 1)
//   pulse_in      one-cycle trigger to the measurement block
//   pulse_length  measured length, qualified by valid
//   valid         one-cycle qualifier for pulse_length
//   avg_out       last average, held until the next result
//   avg_valid     one-cycle strobe marking a new avg_out
//   busy          high whenever the sequencer is not IDLE
//   timeout_err   sticky abort flag, cleared by the next accepted start
module temp_sensor_avg_ctrl #(
    parameter int TS_COUNT_WIDTH = 32,
    parameter int AVG_LOG2       = 3,
    parameter int PERIOD_WIDTH   = 32,
    parameter int TIMEOUT        = 100000
) (
    input  logic                      clk_100MHz,
    input  logic                      RESET_N,
    input  logic                      start,
    input  logic                      continuous,
    input  logic [PERIOD_WIDTH-1:0]   interval,
    output logic                      pulse_in,
    input  logic [TS_COUNT_WIDTH-1:0] pulse_length,
    input  logic                      valid,
    output logic [TS_COUNT_WIDTH-1:0] avg_out,
    output logic                      avg_valid,
    output logic                      busy,
    output logic                      timeout_err
);

    // The accumulator carries AVG_LOG2 extra bits so that N maximum-valued
    // samples can never overflow it.
    localparam int ACC_W = TS_COUNT_WIDTH + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t                  state;
    logic [ACC_W-1:0]        acc;
    logic [CNT_W-1:0]        cnt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [PERIOD_WIDTH-1:0] gap_cnt;

    logic [ACC_W-1:0]        acc_sum;
    logic [PERIOD_WIDTH-1:0] gap_load;

    always_comb begin
        acc_sum  = acc + ACC_W'(pulse_length);
        // A zero interval still costs one GAP cycle.
        gap_load = (interval == '0) ? PERIOD_WIDTH'(1) : interval;
    end

    always_ff @(posedge clk_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            pulse_in    <= 1'b0;
            avg_valid   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            avg_out     <= '0;
            acc         <= '0;
            cnt         <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            pulse_in  <= 1'b0;
            avg_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    acc <= '0;
                    cnt <= '0;
                    if (start) begin
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_TRIG;
                    end
                end
                // pulse_in is registered, so the trigger appears on the
                // wire during the first WAIT cycle.
                S_TRIG: begin
                    pulse_in <= 1'b1;
                    tmo_cnt  <= TMO_W'(TIMEOUT);
                    state    <= S_WAIT;
                end
                // A result arriving in the last timeout cycle is still
                // accepted: valid is tested before expiry.
                S_WAIT: begin
                    if (valid) begin
                        acc <= acc_sum;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_IDX) begin
                            avg_out   <= TS_COUNT_WIDTH'(acc_sum >> AVG_LOG2);
                            avg_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            gap_cnt <= gap_load;
                            state   <= S_GAP;
                        end
                    end else if (tmo_cnt <= TMO_W'(1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt <= PERIOD_WIDTH'(1)) begin
                        state <= S_TRIG;
                    end else begin
                        gap_cnt <= gap_cnt - PERIOD_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    if (continuous) begin
                        acc     <= '0;
                        cnt     <= '0;
                        gap_cnt <= gap_load;
                        state   <= S_GAP;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_sensor_avg_ctrl.sv
// Scoreboard bench for temp_sensor_avg_ctrl. Instance A (AVG_LOG2=2,
// TIMEOUT=200) covers single runs, truncation, timeout, spurious inputs and
// reset mid-run; instance B (AVG_LOG2=0) covers continuous mode.
module tb_temp_sensor_avg_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    logic        start_a = 0, cont_a = 0;
    logic [31:0] interval_a = 0;
    logic        pulse_a, avgv_a, busy_a, terr_a;
    logic [31:0] avg_a;
    logic        mdl_v_a = 0, sp_v_a = 0;
    logic [31:0] mdl_l_a = 0, sp_l_a = 0;
    logic        valid_a;
    logic [31:0] len_a;
    assign valid_a = mdl_v_a | sp_v_a;
    assign len_a   = sp_v_a ? sp_l_a : mdl_l_a;

    temp_sensor_avg_ctrl #(
        .TS_COUNT_WIDTH(32), .AVG_LOG2(2), .PERIOD_WIDTH(32), .TIMEOUT(200)
    ) dut_a (
        .clk_100MHz(clk), .RESET_N(rst_n), .start(start_a), .continuous(cont_a),
        .interval(interval_a), .pulse_in(pulse_a), .pulse_length(len_a),
        .valid(valid_a), .avg_out(avg_a), .avg_valid(avgv_a), .busy(busy_a),
        .timeout_err(terr_a)
    );

    // ---------------- instance B ----------------
    logic        start_b = 0, cont_b = 0;
    logic [31:0] interval_b = 0;
    logic        pulse_b, avgv_b, busy_b, terr_b;
    logic [31:0] avg_b;
    logic        valid_b = 0;
    logic [31:0] len_b = 32'd500;

    temp_sensor_avg_ctrl #(
        .TS_COUNT_WIDTH(32), .AVG_LOG2(0), .PERIOD_WIDTH(32), .TIMEOUT(200)
    ) dut_b (
        .clk_100MHz(clk), .RESET_N(rst_n), .start(start_b), .continuous(cont_b),
        .interval(interval_b), .pulse_in(pulse_b), .pulse_length(len_b),
        .valid(valid_b), .avg_out(avg_b), .avg_valid(avgv_b), .busy(busy_b),
        .timeout_err(terr_b)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- sensor models ----------------
    int          dly_a = 30, cnt_a = 0, n_valid_a = 0;
    logic        resp_a = 1;
    logic [31:0] lq_a[$];

    initial forever begin
        @(negedge clk);
        mdl_v_a = 0;
        if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) begin
                mdl_v_a = 1;
                mdl_l_a = (lq_a.size() > 0) ? lq_a.pop_front() : 32'd0;
                n_valid_a++;
            end
        end
        if (pulse_a && resp_a) cnt_a = dly_a;
    end

    int dly_b = 4, cnt_b = 0;
    initial forever begin
        @(negedge clk);
        valid_b = 0;
        if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) valid_b = 1;
        end
        if (pulse_b) cnt_b = dly_b;
    end

    // ---------------- scoreboards / monitors ----------------
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int pulse_cyc_a[$];
    int busy_fall_a = -1, terr_rise_a = -1, done_cyc_a = -1;
    logic prev_busy_a = 0, prev_terr_a = 0;
    int n_avg_b = 0, last_done_b = -1;

    initial forever begin
        @(negedge clk);
        if (pulse_a) pulse_cyc_a.push_back(cyc);
        if (avgv_a) begin
            done_cyc_a = cyc;
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL avg_a strobe: got unexpected avg_valid with %0h, required none", avg_a);
            end else chk("avg_a", avg_a, exp_a.pop_front());
        end
        if (prev_busy_a && !busy_a) busy_fall_a = cyc;
        if (!prev_terr_a && terr_a) terr_rise_a = cyc;
        prev_busy_a = busy_a;
        prev_terr_a = terr_a;
    end

    initial forever begin
        @(negedge clk);
        if (avgv_b) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL avg_b strobe: got unexpected avg_valid with %0h, required none", avg_b);
            end else chk("avg_b", avg_b, exp_b.pop_front());
            if (last_done_b >= 0) chk("avg_b period", cyc - last_done_b, 17);
            last_done_b = cyc;
            n_avg_b++;
        end
    end

    // ---------------- helpers ----------------
    task automatic go_a();
        @(negedge clk); start_a = 1;
        @(negedge clk); start_a = 0;
    endtask

    task automatic wait_idle_a(input int lim, input string nm);
        int n = 0;
        while (busy_a !== 1'b0 && n < lim) begin @(negedge clk); n++; end
        chk(nm, busy_a, 0);
    endtask

    task automatic load4_a(input logic [31:0] v0, v1, v2, v3);
        lq_a.delete();
        lq_a.push_back(v0); lq_a.push_back(v1);
        lq_a.push_back(v2); lq_a.push_back(v3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("reset avg_out", avg_a, 0);
        chk("reset busy", busy_a, 0);
        chk("reset pulse_in", pulse_a, 0);
        chk("reset timeout_err", terr_a, 0);
        chk("reset avg_valid", avgv_a, 0);
        rst_n = 1;
        @(negedge clk);

        // 1: single run, pulse spacing and busy drop
        interval_a = 50; dly_a = 30;
        load4_a(100, 102, 104, 106);
        exp_a.push_back(32'd103);
        pulse_cyc_a.delete();
        go_a();
        wait_idle_a(1000, "run1 completes");
        chk("run1 pulse count", pulse_cyc_a.size(), 4);
        for (int i = 1; i < 4 && i < pulse_cyc_a.size(); i++)
            chk("run1 pulse spacing", pulse_cyc_a[i] - pulse_cyc_a[i-1], 82);
        chk("run1 busy drop after DONE", busy_fall_a - done_cyc_a, 1);

        // 2: truncation and maximum values
        interval_a = 3; dly_a = 5;
        load4_a(1, 1, 1, 2);
        exp_a.push_back(32'd1);
        go_a();
        wait_idle_a(500, "run2a completes");
        load4_a(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp_a.push_back(32'hFFFF_FFFF);
        go_a();
        wait_idle_a(500, "run2b completes");

        // 3: timeout, clear on start, valid exactly at expiry
        resp_a = 0;
        pulse_cyc_a.delete();
        go_a();
        wait_idle_a(400, "timeout returns idle");
        chk("timeout_err set", terr_a, 1);
        chk("timeout pulse count", pulse_cyc_a.size(), 1);
        if (pulse_cyc_a.size() > 0)
            chk("timeout latency", terr_rise_a - pulse_cyc_a[0], 200);
        chk("avg_out held after timeout", avg_a, 32'hFFFF_FFFF);
        resp_a = 1; dly_a = 199; interval_a = 0;
        load4_a(10, 10, 10, 10);
        exp_a.push_back(32'd10);
        pulse_cyc_a.delete();
        go_a();
        chk("timeout_err cleared by start", terr_a, 0);
        wait_idle_a(2000, "expiry-edge run completes");
        chk("no error with valid at expiry", terr_a, 0);
        if (pulse_cyc_a.size() > 1)
            chk("interval 0 spacing", pulse_cyc_a[1] - pulse_cyc_a[0], 202);
        else chk("expiry run pulse count", pulse_cyc_a.size(), 4);

        // 5: spurious valid and start
        interval_a = 50; dly_a = 10;
        load4_a(20, 22, 24, 26);
        exp_a.push_back(32'd23);
        @(negedge clk); sp_v_a = 1; sp_l_a = 9999;
        @(negedge clk); sp_v_a = 0;
        pulse_cyc_a.delete();
        go_a();
        repeat (4) @(negedge clk);
        start_a = 1; @(negedge clk); start_a = 0;
        repeat (24) @(negedge clk);
        sp_v_a = 1; sp_l_a = 9999; start_a = 1;
        @(negedge clk); sp_v_a = 0; start_a = 0;
        wait_idle_a(1000, "spurious run completes");
        chk("spurious pulse count", pulse_cyc_a.size(), 4);
        @(negedge clk); sp_v_a = 1; sp_l_a = 9999;
        @(negedge clk); sp_v_a = 0;
        repeat (3) @(negedge clk);
        chk("avg_out after idle valid", avg_a, 23);
        chk("no restart from idle valid", busy_a, 0);

        // 4: continuous mode on instance B
        interval_b = 10; cont_b = 1;
        repeat (4) exp_b.push_back(32'd500);
        @(negedge clk); start_b = 1;
        @(negedge clk); start_b = 0;
        for (int n = 0; n < 500 && n_avg_b < 3; n++) @(negedge clk);
        chk("continuous results before drop", n_avg_b, 3);
        repeat (3) @(negedge clk);
        cont_b = 0;
        for (int n = 0; n < 200 && busy_b; n++) @(negedge clk);
        chk("continuous stops", busy_b, 0);
        repeat (40) @(negedge clk);
        chk("continuous total results", n_avg_b, 4);
        chk("continuous no timeout", terr_b, 0);

        // 6: reset mid-run
        interval_a = 5; dly_a = 5;
        load4_a(7, 7, 7, 7);
        n_valid_a = 0;
        go_a();
        for (int n = 0; n < 200 && n_valid_a < 2; n++) @(negedge clk);
        chk("two samples before reset", n_valid_a, 2);
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        chk("async reset busy", busy_a, 0);
        chk("async reset avg_out", avg_a, 0);
        chk("async reset avg_valid", avgv_a, 0);
        chk("async reset pulse_in", pulse_a, 0);
        cnt_a = 0; lq_a.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        load4_a(40, 41, 42, 43);
        exp_a.push_back(32'd41);
        go_a();
        wait_idle_a(500, "post-reset run completes");
        chk("post-reset avg_out", avg_a, 41);

        repeat (5) @(negedge clk);
        chk("scoreboard A drained", exp_a.size(), 0);
        chk("scoreboard B drained", exp_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/temp_sensor_avg_ctrl.md
Name: temp_sensor_avg_ctrl

Overview:
- Sequencer and averager placed around the temperature-sensor pulse-length measurement block.
- Issues `pulse_in` triggers to that block at a programmable interval and collects 2^AVG_LOG2 `pulse_length` results, each qualified by `valid`.
- Publishes the truncated mean as a single registered result with a one-cycle strobe, and supports single-shot and continuous modes.
- Flags a missing sensor response with a timeout error.

Parameters:
TS_COUNT_WIDTH, 32, width of `pulse_length` and `avg_out`
AVG_LOG2, 3, log2 of samples per average (N = 2^AVG_LOG2; 0 means a single sample)
PERIOD_WIDTH, 32, width of `interval`
TIMEOUT, 100000, max cycles in WAIT before abort (must be >= 1)

Ports:
clk_100MHz  in  1  system clock, all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
start  in  1  request one averaging run; sampled only in IDLE
continuous  in  1  when high, a completed run auto-restarts after `interval`
interval  in  PERIOD_WIDTH  idle cycles between consecutive triggers
pulse_in  out  1  one-cycle trigger to the measurement block
pulse_length  in  TS_COUNT_WIDTH  measured length from the measurement block
valid  in  1  `pulse_length` qualifier, one cycle
avg_out  out  TS_COUNT_WIDTH  last average, held until next result
avg_valid  out  1  one-cycle strobe, `avg_out` updated
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (async, RESET_N=0):
  - State goes to IDLE.
  - `pulse_in`, `avg_valid`, `busy`, `timeout_err` = 0; `avg_out` = 0.
  - Accumulator, sample count and timers = 0.
- Reset mid-run abandons the run with no `avg_valid`. Normal operation resumes on the first edge after release.
- States: IDLE, TRIG, WAIT, GAP, DONE. All outputs are registered.
- IDLE:
  - On `start`=1 go to TRIG.
  - Clear the accumulator (width TS_COUNT_WIDTH+AVG_LOG2, cannot overflow) and the sample count.
  - Clear `timeout_err`.
- TRIG:
  - `pulse_in`=1 for exactly this one cycle.
  - Load the timeout counter with TIMEOUT, then go to WAIT.
  - Latency: `start` sampled at edge 0 gives `pulse_in` high in the cycle after edge 1.
- WAIT (timeout counter decrements each cycle):
  - `valid`=1: acc += `pulse_length`, count += 1.
    - If this was sample N, go to DONE.
    - Otherwise go to GAP, loading the gap counter with `interval`.
  - Counter reaches 0 with `valid`=0: set `timeout_err`=1 and go to IDLE. No `avg_valid`; `avg_out` is unchanged.
  - `valid` and expiry in the same cycle: `valid` wins.
- GAP:
  - Count down `interval` cycles, then go to TRIG.
  - `interval`=0 behaves as 1 (single GAP cycle).
  - `interval` is sampled only on GAP entry.
- DONE:
  - `avg_out` = (acc including final sample) >> AVG_LOG2, truncated.
  - `avg_valid`=1 for this cycle only, i.e. the cycle after the edge sampling the final `valid`.
  - Next state: if `continuous`=1 (sampled in DONE), clear acc/count and go to GAP. Otherwise go to IDLE.
- Input qualification:
  - `valid` outside WAIT is ignored and does not change acc or count.
  - `start` outside IDLE is ignored.
  - Deasserting `continuous` mid-run lets the current run finish, then the block goes to IDLE.
- `timeout_err` stays set until the next accepted `start` or reset. It does not self-clear in continuous mode, because an abort always returns to IDLE.

Test Plan:
1. Single run averaging:
   - Setup: AVG_LOG2=2, interval=50, bench sensor model returns `valid` 30 cycles after each `pulse_in` with lengths 100, 102, 104, 106.
   - Required: exactly 4 `pulse_in` pulses, spaced 30+1+50+1 cycles apart; one `avg_valid` with `avg_out`=103; `busy` drops the cycle after DONE.
2. Truncation and max value:
   - Setup: AVG_LOG2=2, lengths 1, 1, 1, 2.
   - Required: `avg_out`=1.
   - Setup: all four lengths 0xFFFFFFFF.
   - Required: `avg_out`=0xFFFFFFFF (no accumulator overflow).
3. Timeout:
   - Setup: TIMEOUT=200, model never asserts `valid`.
   - Required: `timeout_err`=1 exactly 200 cycles into WAIT; state IDLE; no `avg_valid`; `avg_out` keeps its previous value.
   - Then: next `start`.
   - Required: `timeout_err` clears.
   - Setup: `valid` exactly at expiry.
   - Required: accepted, no error.
4. Continuous mode:
   - Setup: `continuous`=1, AVG_LOG2=0, interval=10, constant length 500.
   - Required: `avg_valid` repeats every 10+1+1+latency cycles with `avg_out`=500.
   - Then: drop `continuous` mid-GAP.
   - Required: one more result, then IDLE.
5. Spurious inputs:
   - Stimulus: `valid` pulses in IDLE/GAP with length 9999, and `start` pulses while `busy`.
   - Required: average unaffected; no extra `pulse_in`.
6. Reset mid-run:
   - Stimulus: assert RESET_N=0 asynchronously (between edges) after 2 of 4 samples.
   - Required: all outputs 0 immediately, with no `avg_valid`.
   - Then: a subsequent `start`.
   - Required: the run starts from zero and averages only the new samples.
